// File: rtl/display_resultado_pkg.sv
`default_nettype none
// ============================================================================
// display_resultado_pkg : seven-segment tables, digit encodings, polarity helper
// Revision: 1.0
// ============================================================================
package display_resultado_pkg;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } dig_e;

  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high segment patterns, bits g..a; entry n is the glyph for hex digit n
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // {an, seg, dp} bundle converted from active-high to the board polarity
  function automatic logic [11:0] apply_pol(input logic [11:0] v, input logic active_low);
    return active_low ? ~v : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/display_resultado_if.sv
`default_nettype none
// ============================================================================
// display_resultado_if : ALU result inputs and multiplexed display outputs
// Revision: 1.0
// ============================================================================
interface display_resultado_if;
  logic [7:0] rdo;
  logic       carry;
  logic       zero;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  modport master (output rdo, carry, zero, input  an, seg, dp, frame_tick);
  modport slave  (input  rdo, carry, zero, output an, seg, dp, frame_tick);
endinterface
`default_nettype wire

// File: rtl/display_resultado_hex_a_7seg.sv
`default_nettype none
// ============================================================================
// hex_a_7seg : combinational 4-bit hex to active-high seven-segment decoder
// Revision: 1.0
// ============================================================================
module hex_a_7seg
  import display_resultado_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[hex_i];

endmodule
`default_nettype wire

// File: rtl/display_resultado.sv
`default_nettype none
// ============================================================================
// display_resultado : 4-digit multiplexed 7-seg view of the ALU result bus
// Revision: 1.0
// ============================================================================
module display_resultado
  import display_resultado_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter bit ACTIVE_LOW_OUT = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  display_resultado_if.slave  bus
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  dig_e             idx_q, idx_d;
  logic [7:0]       rdo_q;
  logic             carry_q, zero_q;
  logic             en_q;
  logic             first_q;
  logic             frame_tick_q;
  logic [11:0]      out_q, out_d;
  logic             tick;
  logic             load;
  logic [3:0]       nib;
  logic [6:0]       hex_seg;
  logic [3:0]       an_d;
  logic [6:0]       seg_d;
  logic             dp_d;

  assign tick  = (cnt_q == CNT_LAST);
  assign load  = tick && (idx_q == DIG3);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;
  assign idx_d = tick ? dig_e'(idx_q + 2'd1) : idx_q;
  assign nib   = (idx_q == DIG1) ? rdo_q[7:4] : rdo_q[3:0];

  hex_a_7seg u_hex (
    .hex_i (nib),
    .seg_o (hex_seg)
  );

  always_comb begin
    an_d  = 4'b1000;
    seg_d = SEG_BLANK;
    dp_d  = 1'b0;
    case (idx_q)
      DIG0: begin an_d = 4'b0001; seg_d = hex_seg; dp_d = zero_q; end
      DIG1: begin an_d = 4'b0010; seg_d = hex_seg; end
      DIG2: begin an_d = 4'b0100; seg_d = carry_q ? SEG_C : SEG_BLANK; end
      default: ;
    endcase
    // Display stays dark until the first frame snapshot has been taken
    out_d = apply_pol(en_q ? {an_d, seg_d, dp_d} : 12'h000, ACTIVE_LOW_OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= DIG3;
      rdo_q        <= '0;
      carry_q      <= 1'b0;
      zero_q       <= 1'b0;
      en_q         <= 1'b0;
      first_q      <= 1'b0;
      frame_tick_q <= 1'b0;
      out_q        <= apply_pol(12'h000, ACTIVE_LOW_OUT);
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      first_q      <= load;
      frame_tick_q <= first_q;
      out_q        <= out_d;
      if (tick) begin
        en_q <= 1'b1;
      end
      if (load) begin
        rdo_q   <= bus.rdo;
        carry_q <= bus.carry;
        zero_q  <= bus.zero;
      end
    end
  end

  assign bus.an         = out_q[11:8];
  assign bus.seg        = out_q[7:1];
  assign bus.dp         = out_q[0];
  assign bus.frame_tick = frame_tick_q;

endmodule
`default_nettype wire
